hsync_timing_rx: RTL and testbench

Receive-side counterpart of the horizontal timing generator. Consumes an incoming active-low hsync and a data-enable (DE) in the pixel clock domain. Measures line period, sync width, back porch and active width, then locks once the timing is consistent. While locked it regenerates active_o and col_o for downstream pixel capture, and it serves as a loop-back checker for the generator.

---
 rtl/vga_timing_pkg.sv | 16 +
 rtl/sig_edge_det.sv | 29 ++
 rtl/hsync_timing_rx.sv | 254 +++++++++++++++++++++++++
 tb/tb_hsync_timing_rx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared definitions for the horizontal timing generator and its receiver.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } rx_state_e;

  localparam int H_ACTIVE = 480;
  localparam int H_FRONT  = 2;
  localparam int H_SYNC   = 41;
  localparam int H_BACK   = 2;
  localparam int H_TOTAL  = 525;

endpackage

// File: rtl/sig_edge_det.sv
// Registers one input and flags its rising and falling edges against the
// previous registered value.
module sig_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic r_q;
  logic r_q_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q   <= 1'b0;
      r_q_d <= 1'b0;
    end else begin
      r_q   <= i_sig;
      r_q_d <= r_q;
    end
  end

  assign o_q    = r_q;
  assign o_rise = r_q & ~r_q_d;
  assign o_fall = ~r_q & r_q_d;

endmodule

// File: rtl/hsync_timing_rx.sv
// Horizontal timing receiver: measures hsync/DE line timing, locks onto a
// consistent line and regenerates active/column for pixel capture.
//
// state   | meaning
// SEARCH  | waiting for an hsync fall to start measuring
// MEASURE | comparing each line to a reference, counting matches
// LOCKED  | reference frozen, regenerating active/col, counting misses
module hsync_timing_rx
  import vga_timing_pkg::*;
#(
  parameter int CNT_W      = 10,
  parameter int LOCK_LINES = 4,
  parameter int TOL        = 1,
  parameter int MISS_MAX   = 2
) (
  input  logic             pxclk_i,
  input  logic             rst_ni,
  input  logic             hsync_i,
  input  logic             de_i,
  output logic             active_o,
  output logic [CNT_W-1:0] col_o,
  output logic             locked_o,
  output logic             line_start_o,
  output logic             err_o,
  output logic [CNT_W-1:0] line_len_o,
  output logic [CNT_W-1:0] sync_len_o,
  output logic [CNT_W-1:0] bporch_o,
  output logic [CNT_W-1:0] act_len_o
);

  localparam int MC_W = $clog2(LOCK_LINES + 1);
  localparam int MS_W = $clog2(MISS_MAX + 1);
  localparam logic [CNT_W-1:0] POS_MAX = '1;
  localparam logic [CNT_W-1:0] POS_ONE = CNT_W'(1);
  localparam logic signed [CNT_W:0] TOL_S = (CNT_W + 1)'(TOL);

  logic w_hs_q, w_hs_rise, w_hs_fall;
  logic w_de_q, w_de_rise, w_de_fall;

  sig_edge_det u_hs_edge (
    .i_clk   (pxclk_i),
    .i_rst_n (rst_ni),
    .i_sig   (hsync_i),
    .o_q     (w_hs_q),
    .o_rise  (w_hs_rise),
    .o_fall  (w_hs_fall)
  );

  sig_edge_det u_de_edge (
    .i_clk   (pxclk_i),
    .i_rst_n (rst_ni),
    .i_sig   (de_i),
    .o_q     (w_de_q),
    .o_rise  (w_de_rise),
    .o_fall  (w_de_fall)
  );

  logic [CNT_W-1:0] r_pos;
  logic [CNT_W-1:0] r_sync_meas;
  logic [CNT_W-1:0] r_bp_meas;
  logic [CNT_W-1:0] r_act_meas;
  logic [CNT_W-1:0] r_de_rise_pos;
  logic             r_de_seen;
  logic             r_act_done;

  logic [CNT_W-1:0] w_pos_inc;
  logic [CNT_W-1:0] w_sync_now;
  logic [CNT_W-1:0] w_act_now;
  logic             w_de_first;
  logic             w_timeout;

  assign w_pos_inc  = r_pos + POS_ONE;
  assign w_sync_now = w_hs_rise ? w_pos_inc : r_sync_meas;
  // only the first DE rise after the sync pulse ends defines the back porch
  assign w_de_first = w_de_rise & w_hs_q & ~r_de_seen;
  assign w_timeout  = (r_pos == POS_MAX - POS_ONE);
  // DE still high on the hsync fall closes the active run on this cycle
  assign w_act_now  = (w_de_q & r_de_seen & ~r_act_done)
                    ? (r_pos - r_de_rise_pos + POS_ONE) : r_act_meas;

  always_ff @(posedge pxclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pos         <= '0;
      r_sync_meas   <= '0;
      r_bp_meas     <= '0;
      r_act_meas    <= '0;
      r_de_rise_pos <= '0;
      r_de_seen     <= 1'b0;
      r_act_done    <= 1'b0;
    end else begin
      if (w_hs_fall) begin
        r_pos <= '0;
      end else if (r_pos != POS_MAX) begin
        r_pos <= w_pos_inc;
      end

      if (w_hs_fall) begin
        r_de_seen  <= 1'b0;
        r_act_done <= 1'b0;
      end else begin
        if (w_hs_rise) begin
          r_sync_meas <= w_pos_inc;
        end
        if (w_de_first) begin
          r_de_seen     <= 1'b1;
          r_de_rise_pos <= r_pos;
          r_bp_meas     <= w_pos_inc - w_sync_now;
        end
        if (w_de_fall && r_de_seen && !r_act_done) begin
          r_act_done <= 1'b1;
          r_act_meas <= r_pos - r_de_rise_pos;
        end
      end
    end
  end

  function automatic logic within_tol(input logic [CNT_W-1:0] a,
                                      input logic [CNT_W-1:0] b);
    logic signed [CNT_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d <= TOL_S) && (d >= -TOL_S);
  endfunction

  rx_state_e        r_state, w_state_nxt;
  logic [MC_W-1:0]  r_match_cnt, w_match_nxt;
  logic [MS_W-1:0]  r_miss_cnt, w_miss_nxt;
  logic             r_ref_vld, w_ref_vld_nxt;
  logic [CNT_W-1:0] r_ref_line, w_ref_line_nxt;
  logic [CNT_W-1:0] r_ref_sync, w_ref_sync_nxt;
  logic             w_match;
  logic             w_err;
  logic             w_eval;

  assign w_match = within_tol(w_pos_inc, r_ref_line)
                 & within_tol(r_sync_meas, r_ref_sync);
  assign w_eval  = w_hs_fall & ~w_timeout & (r_state != SEARCH);

  always_ff @(posedge pxclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= SEARCH;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_ref_vld   <= 1'b0;
      r_ref_line  <= '0;
      r_ref_sync  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_match_cnt <= w_match_nxt;
      r_miss_cnt  <= w_miss_nxt;
      r_ref_vld   <= w_ref_vld_nxt;
      r_ref_line  <= w_ref_line_nxt;
      r_ref_sync  <= w_ref_sync_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_match_nxt    = r_match_cnt;
    w_miss_nxt     = r_miss_cnt;
    w_ref_vld_nxt  = r_ref_vld;
    w_ref_line_nxt = r_ref_line;
    w_ref_sync_nxt = r_ref_sync;
    w_err          = 1'b0;
    if (w_timeout) begin
      w_state_nxt = SEARCH;
      w_err       = 1'b1;
    end else if (w_hs_fall) begin
      unique case (r_state)
        SEARCH: begin
          w_state_nxt   = MEASURE;
          w_match_nxt   = '0;
          w_ref_vld_nxt = 1'b0;
        end
        MEASURE: begin
          if (!r_ref_vld || !w_match) begin
            w_ref_vld_nxt  = 1'b1;
            w_ref_line_nxt = w_pos_inc;
            w_ref_sync_nxt = r_sync_meas;
            w_match_nxt    = '0;
            w_err          = r_ref_vld;
          end else if (r_match_cnt == MC_W'(LOCK_LINES - 2)) begin
            w_state_nxt = LOCKED;
            w_miss_nxt  = '0;
          end else begin
            w_match_nxt = r_match_cnt + MC_W'(1);
          end
        end
        LOCKED: begin
          if (w_match) begin
            w_miss_nxt = '0;
          end else begin
            w_err = 1'b1;
            if (r_miss_cnt == MS_W'(MISS_MAX - 1)) begin
              w_state_nxt = SEARCH;
            end else begin
              w_miss_nxt = r_miss_cnt + MS_W'(1);
            end
          end
        end
        default: w_state_nxt = SEARCH;
      endcase
    end
  end

  logic             r_line_start;
  logic             r_err;
  logic             r_active;
  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_line_len;
  logic [CNT_W-1:0] r_sync_len;
  logic [CNT_W-1:0] r_bporch;
  logic [CNT_W-1:0] r_act_len;
  logic             w_active_nxt;

  // gate on the next state so active drops together with locked_o
  assign w_active_nxt = w_de_q & (w_state_nxt == LOCKED);

  always_ff @(posedge pxclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_line_start <= 1'b0;
      r_err        <= 1'b0;
      r_active     <= 1'b0;
      r_col        <= '0;
      r_line_len   <= '0;
      r_sync_len   <= '0;
      r_bporch     <= '0;
      r_act_len    <= '0;
    end else begin
      r_line_start <= w_hs_fall;
      r_err        <= w_err;
      r_active     <= w_active_nxt;
      r_col        <= (w_active_nxt && r_active) ? r_col + POS_ONE : '0;
      if (w_eval) begin
        r_line_len <= w_pos_inc;
        r_sync_len <= r_sync_meas;
        if (r_de_seen) begin
          r_bporch  <= r_bp_meas;
          r_act_len <= w_act_now;
        end
      end
    end
  end

  assign active_o     = r_active;
  assign col_o        = r_col;
  assign locked_o     = (r_state == LOCKED);
  assign line_start_o = r_line_start;
  assign err_o        = r_err;
  assign line_len_o   = r_line_len;
  assign sync_len_o   = r_sync_len;
  assign bporch_o     = r_bporch;
  assign act_len_o    = r_act_len;

endmodule

// File: tb/tb_hsync_timing_rx.sv
// Self-checking bench for hsync_timing_rx: line-level reference model driven
// by directed and randomized line timings.
module tb_hsync_timing_rx;
  import vga_timing_pkg::*;

  localparam int CNT_W      = 10;
  localparam int LOCK_LINES = 4;
  localparam int TOL        = 1;
  localparam int MISS_MAX   = 2;
  localparam int TO_K       = (1 << CNT_W) + 1;

  logic             pxclk_i = 1'b0;
  logic             rst_ni  = 1'b0;
  logic             hsync_i = 1'b1;
  logic             de_i    = 1'b0;
  logic             active_o;
  logic [CNT_W-1:0] col_o;
  logic             locked_o;
  logic             line_start_o;
  logic             err_o;
  logic [CNT_W-1:0] line_len_o;
  logic [CNT_W-1:0] sync_len_o;
  logic [CNT_W-1:0] bporch_o;
  logic [CNT_W-1:0] act_len_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 pxclk_i = ~pxclk_i;

  hsync_timing_rx #(
    .CNT_W      (CNT_W),
    .LOCK_LINES (LOCK_LINES),
    .TOL        (TOL),
    .MISS_MAX   (MISS_MAX)
  ) dut (
    .pxclk_i      (pxclk_i),
    .rst_ni       (rst_ni),
    .hsync_i      (hsync_i),
    .de_i         (de_i),
    .active_o     (active_o),
    .col_o        (col_o),
    .locked_o     (locked_o),
    .line_start_o (line_start_o),
    .err_o        (err_o),
    .line_len_o   (line_len_o),
    .sync_len_o   (sync_len_o),
    .bporch_o     (bporch_o),
    .act_len_o    (act_len_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // line-level model: mode 0 = searching, 1 = acquiring, 2 = locked
  int m_mode, m_match, m_miss, m_ref_len, m_ref_sync;
  bit m_have_ref;
  int e_line_len, e_sync_len, e_bporch, e_act_len;
  int p_len, p_sync, p_bp, p_act;
  bit p_de;

  function automatic bit near(input int a, input int b);
    return (a - b <= TOL) && (b - a <= TOL);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_match = 0; m_miss = 0; m_have_ref = 0;
    m_ref_len = 0; m_ref_sync = 0;
    e_line_len = 0; e_sync_len = 0; e_bporch = 0; e_act_len = 0;
  endtask

  // called when an hsync fall ends the previous line (p_*)
  task automatic model_fall(output bit err);
    bit ok;
    err = 1'b0;
    if (m_mode == 0) begin
      m_mode = 1; m_have_ref = 0; m_match = 0;
    end else begin
      e_line_len = p_len;
      e_sync_len = p_sync;
      if (p_de) begin
        e_bporch  = p_bp;
        e_act_len = p_act;
      end
      ok = near(p_len, m_ref_len) && near(p_sync, m_ref_sync);
      if (m_mode == 1) begin
        if (!m_have_ref || !ok) begin
          err = m_have_ref;
          m_have_ref = 1; m_ref_len = p_len; m_ref_sync = p_sync; m_match = 0;
        end else begin
          m_match++;
          if (m_match == LOCK_LINES - 1) begin
            m_mode = 2; m_miss = 0;
          end
        end
      end else if (ok) begin
        m_miss = 0;
      end else begin
        err = 1'b1;
        m_miss++;
        if (m_miss == MISS_MAX) m_mode = 0;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_active"}, active_o, 0);
    check_eq({tag, "_col"}, col_o, 0);
    check_eq({tag, "_locked"}, locked_o, 0);
    check_eq({tag, "_lstart"}, line_start_o, 0);
    check_eq({tag, "_err"}, err_o, 0);
    check_eq({tag, "_line_len"}, line_len_o, 0);
    check_eq({tag, "_sync_len"}, sync_len_o, 0);
    check_eq({tag, "_bporch"}, bporch_o, 0);
    check_eq({tag, "_act_len"}, act_len_o, 0);
  endtask

  // one line starting with the hsync fall; rst_k >= 0 aborts it with a reset
  task automatic drive_line(input int len, input int sync, input int bp,
                            input int act, input bit has_de, input int rst_k);
    bit ev_err;
    bit e_act;
    int idx, e_col;
    ev_err = 1'b0;
    for (int k = 0; k < len; k++) begin
      @(negedge pxclk_i);
      if (k == rst_k) begin
        rst_ni = 1'b0; hsync_i = 1'b1; de_i = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        repeat (3) @(negedge pxclk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge pxclk_i);
        return;
      end
      if (k == 2) model_fall(ev_err);
      if (k == TO_K) m_mode = 0;
      check_eq("err", err_o, ((k == 2) && ev_err) || (k == TO_K));
      check_eq("line_start", line_start_o, k == 2);
      check_eq("locked", locked_o, m_mode == 2);
      idx   = k - 2;
      e_act = (m_mode == 2) && has_de && (k >= 2) &&
              (idx >= sync + bp) && (idx < sync + bp + act);
      e_col = e_act ? idx - sync - bp : 0;
      check_eq("active", active_o, e_act);
      check_eq("col", col_o, e_col);
      if (k == 2) begin
        check_eq("line_len", line_len_o, e_line_len);
        check_eq("sync_len", sync_len_o, e_sync_len);
        check_eq("bporch", bporch_o, e_bporch);
        check_eq("act_len", act_len_o, e_act_len);
      end
      hsync_i = (k < sync) ? 1'b0 : 1'b1;
      de_i    = has_de && (k >= sync + bp) && (k < sync + bp + act);
    end
    p_len = len; p_sync = sync; p_bp = bp; p_act = act; p_de = has_de;
  endtask

  task automatic nominal(input int n);
    for (int i = 0; i < n; i++) drive_line(H_TOTAL, H_SYNC, H_BACK, H_ACTIVE, 1'b1, -1);
  endtask

  initial begin
    int seg_len, seg_sync, len, sync, bp, act, max_act;
    bit has_de;
    model_reset();
    p_len = 0; p_sync = 0; p_bp = 0; p_act = 0; p_de = 0;
    repeat (3) @(negedge pxclk_i);
    check_all_zero("reset");
    rst_ni = 1'b1;
    repeat (2) @(negedge pxclk_i);

    // nominal acquisition: locked after the 4th evaluated line
    nominal(6);
    check_eq("nom_locked", locked_o, 1);
    check_eq("nom_line_len", line_len_o, 525);
    check_eq("nom_sync_len", sync_len_o, 41);
    check_eq("nom_bporch", bporch_o, 2);
    check_eq("nom_act_len", act_len_o, 480);

    // jitter within tolerance
    for (int i = 0; i < 8; i++)
      drive_line(H_TOTAL + (i % 2), H_SYNC, H_BACK, H_ACTIVE, 1'b1, -1);

    // randomized segments of near-constant timing with occasional glitches
    for (int s = 0; s < 4; s++) begin
      seg_sync = $urandom_range(60, 10);
      seg_len  = $urandom_range(700, seg_sync + 40);
      for (int i = 0; i < 8; i++) begin
        len  = seg_len + $urandom_range(1, 0);
        sync = seg_sync + (($urandom_range(3, 0) == 0) ? 1 : 0);
        if ($urandom_range(9, 0) == 0) len = len + 30;
        bp      = $urandom_range(6, 1);
        max_act = len - sync - bp - 2;
        act     = ($urandom_range(4, 0) == 0) ? 1 : $urandom_range(max_act, 1);
        has_de  = ($urandom_range(6, 0) != 0);
        drive_line(len, sync, bp, act, has_de, -1);
      end
    end

    // lock drop after two long lines, then reacquire
    nominal(6);
    drive_line(600, H_SYNC, H_BACK, H_ACTIVE, 1'b1, -1);
    drive_line(600, H_SYNC, H_BACK, H_ACTIVE, 1'b1, -1);
    nominal(1);
    check_eq("drop_unlocked", locked_o, 0);
    nominal(6);
    drive_line(600, H_SYNC, H_BACK, H_ACTIVE, 1'b1, -1);
    nominal(2);
    check_eq("single_miss_locked", locked_o, 1);

    // timeout with hsync held high
    drive_line(1200, H_SYNC, H_BACK, H_ACTIVE, 1'b0, -1);
    check_eq("to_locked", locked_o, 0);
    check_eq("to_active", active_o, 0);
    check_eq("to_col", col_o, 0);
    nominal(6);

    // reset in the middle of DE, then relock
    drive_line(H_TOTAL, H_SYNC, H_BACK, H_ACTIVE, 1'b1, 200);
    nominal(6);
    check_eq("relock", locked_o, 1);

    // 1-pixel DE, then a line without DE, then a closing line
    drive_line(H_TOTAL, H_SYNC, H_BACK, 1, 1'b1, -1);
    drive_line(H_TOTAL, H_SYNC, H_BACK, H_ACTIVE, 1'b0, -1);
    check_eq("de1_act_len", act_len_o, 1);
    nominal(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
